// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam int unsigned FETCH_ADDR_W = 32;
   localparam int unsigned FETCH_DATA_W = 32;
   localparam int unsigned PC_STEP      = 4;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

   typedef struct packed {
      logic [FETCH_ADDR_W-1:0] pc;
      logic [FETCH_DATA_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Synchronous FIFO with single-cycle flush; head entry read straight from storage.
module sync_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         wr_en,
   input  logic [WIDTH-1:0]             wr_data,
   input  logic                         rd_en,
   output logic [WIDTH-1:0]             rd_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] cnt;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         if (wr_en) tail <= tail + PTR_W'(1);
         if (rd_en) head <= head + PTR_W'(1);
         if (wr_en && !rd_en)
            cnt <= cnt + CNT_W'(1);
         else if (!wr_en && rd_en)
            cnt <= cnt - CNT_W'(1);
      end
   end

   // Storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[tail] <= wr_data;
   end

   assign rd_data = mem[head];
   assign count   = cnt;
   assign full    = (cnt == CNT_W'(DEPTH));
   assign empty   = (cnt == '0);

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the fetch PC, captures returned instructions and queues
// {pc, instr} pairs for decode; redirect flushes and restarts fetch.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned          ADDR_WIDTH = 32,
   parameter int unsigned          DATA_WIDTH = 32,
   parameter int unsigned          DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         fetch_en,
   input  logic                         redirect,
   input  logic [ADDR_WIDTH-1:0]        redirect_pc,
   output logic [ADDR_WIDTH-1:0]        addr_instr,
   input  logic [DATA_WIDTH-1:0]        instr_in,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ADDR_WIDTH-1:0]        out_pc,
   output logic [DATA_WIDTH-1:0]        out_instr,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

   logic [ADDR_WIDTH-1:0] fetch_pc;
   logic [ADDR_WIDTH-1:0] target_pc;
   logic [ENTRY_W-1:0]    rd_data;
   logic                  full;
   logic                  empty;
   logic                  enq;
   logic                  deq;

   // Redirect wins over both queue operations in its cycle.
   assign deq       = !empty && out_ready && !redirect;
   assign enq       = fetch_en && !redirect && (!full || deq);
   assign target_pc = redirect_pc & ~ADDR_WIDTH'(3);

   always_ff @(posedge clk) begin
      if (!rst_n)
         fetch_pc <= RESET_PC;
      else if (redirect)
         fetch_pc <= target_pc;
      else if (enq)
         fetch_pc <= fetch_pc + ADDR_WIDTH'(PC_STEP);
   end

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (redirect),
      .wr_en   (enq),
      .wr_data ({fetch_pc, instr_in}),
      .rd_en   (deq),
      .rd_data (rd_data),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   assign addr_instr = fetch_pc;
   assign out_valid  = !empty;
   assign out_pc     = rd_data[ENTRY_W-1:DATA_WIDTH];
   assign out_instr  = rd_data[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue against a word-indexed instruction memory.
module tb_fetch_queue;
   import fetch_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        fetch_en;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] addr_instr;
   logic [31:0] instr_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [2:0]  count;

   int unsigned n_checks = 0;
   int unsigned n_fails  = 0;

   fetch_queue #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .DEPTH      (4),
      .RESET_PC   (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fetch_en    (fetch_en),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .addr_instr  (addr_instr),
      .instr_in    (instr_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_instr   (out_instr),
      .count       (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: word i holds 0x1000 + i.
   assign instr_in = 32'h0000_1000 + {2'b00, addr_instr[31:2]};

   function automatic logic [31:0] mem_word(input logic [31:0] pc);
      return 32'h0000_1000 + {2'b00, pc[31:2]};
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_head(input string tag, input logic [31:0] pc, input logic [2:0] cnt);
      fetch_entry_t got;
      fetch_entry_t exp;
      got = '{pc: out_pc, instr: out_instr};
      exp = '{pc: pc, instr: mem_word(pc)};
      check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
      check_eq({tag, "_entry"}, 64'(got), 64'(exp));
      check_eq({tag, "_count"}, 64'(count), 64'(cnt));
   endtask

   initial begin
      rst_n       = 1'b0;
      fetch_en    = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      out_ready   = 1'b0;
      step();
      step();
      check_eq("rst_valid", 64'(out_valid), 64'd0);
      check_eq("rst_count", 64'(count), 64'd0);
      check_eq("rst_addr", 64'(addr_instr), 64'h0);

      // Streaming with decode always ready: one instruction per cycle.
      rst_n     = 1'b1;
      fetch_en  = 1'b1;
      out_ready = 1'b1;
      step();
      for (int i = 0; i < 6; i++) begin
         check_head($sformatf("stream%0d", i), 32'(4 * i), 3'd1);
         step();
      end

      // Restart at 0 with decode stalled to fill the queue.
      out_ready   = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h0;
      step();
      redirect = 1'b0;
      check_eq("flush_valid", 64'(out_valid), 64'd0);
      check_eq("flush_addr", 64'(addr_instr), 64'h0);
      for (int i = 0; i < 10; i++) step();
      check_head("full", 32'h0, 3'd4);
      check_eq("full_addr", 64'(addr_instr), 64'h10);

      // Full with simultaneous dequeue: no bubble, order preserved.
      out_ready = 1'b1;
      for (int j = 1; j <= 5; j++) begin
         step();
         check_head($sformatf("drain%0d", j), 32'(4 * j), 3'd4);
      end
      check_eq("drain_addr", 64'(addr_instr), 64'h24);

      // fetch_en low: PC frozen, dequeue continues.
      fetch_en = 1'b0;
      step();
      check_head("hold", 32'h18, 3'd3);
      check_eq("hold_addr", 64'(addr_instr), 64'h24);

      // Redirect with three entries and decode ready: nothing dequeued.
      fetch_en    = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h203;
      step();
      redirect = 1'b0;
      check_eq("redir_valid", 64'(out_valid), 64'd0);
      check_eq("redir_count", 64'(count), 64'd0);
      check_eq("redir_addr", 64'(addr_instr), 64'h200);
      step();
      check_head("redir_head", 32'h200, 3'd1);

      // PC wraps modulo 2^32.
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      check_eq("wrap_addr0", 64'(addr_instr), 64'hFFFF_FFFC);
      step();
      check_eq("wrap_addr1", 64'(addr_instr), 64'h0);
      check_head("wrap_head", 32'hFFFF_FFFC, 3'd1);
      step();
      check_head("wrap_next", 32'h0, 3'd1);

      // Reset mid-stream discards pending entries.
      out_ready = 1'b0;
      step();
      check_eq("pre_rst_count", 64'(count), 64'd2);
      rst_n = 1'b0;
      step();
      check_eq("mrst_valid", 64'(out_valid), 64'd0);
      check_eq("mrst_count", 64'(count), 64'd0);
      check_eq("mrst_addr", 64'(addr_instr), 64'h0);
      rst_n    = 1'b1;
      fetch_en = 1'b0;
      step();
      check_eq("idle_count", 64'(count), 64'd0);
      check_eq("idle_addr", 64'(addr_instr), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
